axi_ds_slave_model: RTL and testbench
=====================================

Name: axi_ds_slave_model

Overview:
- Synthesizable AXI4 subordinate (responder) model attached to the IOMMU downstream translation-completion port.
- Consumes the AR/AW/W requests issued by the IOMMU and produces R and B responses.
- Responses are protocol-correct: in-order, correct rlast, bounded outstanding count, stable under backpressure. Used as the environment in simulation and as a constrained environment in formal runs.
- Read data is a deterministic address pattern; write data is sunk.

Parameters:
- AddrWidth, 64, AR/AW address width.
- DataWidth, 64, R/W data width.
- IdWidth, 4, AXI ID width.
- DepthBits, 3, log2 of outstanding-request FIFO depth (8 entries) for the AR, AW and B queues.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- ar_valid_i  in  1  read address valid
- ar_ready_o  out  1  read address ready
- ar_addr_i  in  AddrWidth  read address
- ar_len_i  in  8  burst length minus 1
- ar_size_i  in  3  log2 bytes per beat
- ar_id_i  in  IdWidth  read ID
- r_valid_o  out  1  read data valid
- r_ready_i  in  1  read data ready
- r_data_o  out  DataWidth  read data
- r_id_o  out  IdWidth  read ID
- r_resp_o  out  2  read response
- r_last_o  out  1  last read beat
- aw_valid_i  in  1  write address valid
- aw_ready_o  out  1  write address ready
- aw_len_i  in  8  burst length minus 1
- aw_id_i  in  IdWidth  write ID
- w_valid_i  in  1  write data valid
- w_ready_o  out  1  write data ready
- w_last_i  in  1  last write beat
- b_valid_o  out  1  write response valid
- b_ready_i  in  1  write response ready
- b_id_o  out  IdWidth  write response ID
- b_resp_o  out  2  write response
- r_stall_i  in  1  test hook: inhibit start of a new R beat
- protocol_err_o  out  1  sticky wlast-mismatch flag
- rd_outstanding_o  out  DepthBits+1  AR entries queued
- wr_outstanding_o  out  DepthBits+1  AW entries queued

Behaviour:
- Reset values: all valids 0; ar_ready_o=1; aw_ready_o=1; w_ready_o=0; protocol_err_o=0; counters 0; FIFOs empty; beat counters 0.
- Reset asserted mid-burst aborts all state immediately; no response is issued after reset.
- AR path:
  - ar_ready_o = !ar_full.
  - Push {addr,len,size,id} on ar_valid_i&&ar_ready_o.
  - No push when full; a pop in the same cycle does not re-open ready until the next cycle.
- R engine:
  - Asserts r_valid_o when the AR FIFO is non-empty and (!r_stall_i or r_valid_o already 1). r_stall_i never drops an asserted valid.
  - r_id_o = head id; r_resp_o = 2'b00 OKAY.
  - r_data_o = head.addr + (rbeat << head.size), truncated to DataWidth.
  - r_last_o = (rbeat == head.len).
  - While r_valid_o && !r_ready_i, every R output holds stable.
  - On handshake: if last, rbeat←0 and pop AR; else rbeat←rbeat+1 (9-bit).
  - Earliest R beat is one cycle after the AR handshake (registered FIFO output).
  - No interleaving; strictly in AR order.
- AW path:
  - aw_ready_o = !aw_full. Push {len,id}.
  - W data is accepted only against a queued AW: w_ready_o = !aw_empty && !b_full. No early W.
- W beat count:
  - On W handshake: wbeat←wbeat+1.
  - Burst ends when w_last_i=1 or wbeat==head.len, whichever comes first.
  - At burst end: pop AW; wbeat←0; push B {id=head.id, resp}.
  - resp=OKAY if w_last_i==(wbeat==head.len), else SLVERR 2'b10 and protocol_err_o←1 (sticky until reset).
- B path:
  - b_valid_o = !b_empty; outputs from the head; pop on b_ready_i.
  - Stable under backpressure.
  - B never precedes its burst's last W; earliest is the cycle after.
- rd_outstanding_o / wr_outstanding_o equal the AR / AW FIFO occupancy, range 0..8. Push+pop in the same cycle leaves the count unchanged.
- Simultaneous AR and AW handshakes are independent; the read and write paths share no state.

Decomposition:
- Package axi_ds_model_pkg:
  - resp codes OKAY=2'b00, SLVERR=2'b10.
  - ar_entry_t {addr,len,size,id}, aw_entry_t {len,id}, b_entry_t {id,resp}.
- Sub-module axi_model_sync_fifo:
  - Parameters: type T, DepthBits.
  - Ports: push, pop, data in, head, empty, full, count.
  - Instantiated three times (AR, AW, B).

Test Plan:
- AR addr=0x1000 len=3 size=3 id=2, r_ready held 1 → 4 beats, data 0x1000/0x1008/0x1010/0x1018, r_last only on the 4th beat, r_id=2, rd_outstanding 1→0 after the last beat.
- 8 back-to-back ARs with r_stall_i=1 → ar_ready_o=0 on the 9th; rd_outstanding=8; release stall → responses in order, ar_ready_o returns 1 the cycle after the first pop.
- r_ready=0 for 5 cycles mid-burst → r_data/r_id/r_last/r_valid unchanged throughout.
- AW len=1 id=1, then W beats with w_last on the 2nd beat → b_valid with id=1, resp=OKAY the cycle after; W offered before AW → w_ready_o=0.
- AW len=3, w_last asserted on beat 2 → B resp=SLVERR and protocol_err_o=1 sticky; next correct burst returns OKAY.
- Reset asserted during an R burst and with B pending → next cycle all valids 0, counters 0, ar_ready_o=aw_ready_o=1.

Source files
------------

// File: rtl/axi_ds_slave_model_pkg.sv
// Shared types for the IOMMU downstream AXI responder model: response codes and queue entries.
// Entry widths follow the default port widths of the model.
package axi_ds_model_pkg;

    localparam int unsigned AddrWidthMax = 64;
    localparam int unsigned IdWidthMax   = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [AddrWidthMax-1:0] addr;
        logic [7:0]              len;
        logic [2:0]              size;
        logic [IdWidthMax-1:0]   id;
    } ar_entry_t;

    typedef struct packed {
        logic [7:0]            len;
        logic [IdWidthMax-1:0] id;
    } aw_entry_t;

    typedef struct packed {
        logic [IdWidthMax-1:0] id;
        logic [1:0]            resp;
    } b_entry_t;

    function automatic logic beat_is_last(input logic [8:0] beat, input logic [7:0] len);
        return beat == {1'b0, len};
    endfunction

endpackage

// File: rtl/axi_ds_slave_model_fifo.sv
// Generic synchronous FIFO with registered occupancy; a push is visible at the head the next cycle.
// Push is ignored when full and pop is ignored when empty.
module axi_model_sync_fifo #(
    parameter type         T         = logic,
    parameter int unsigned DepthBits = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 i_push,
    input  logic                 i_pop,
    input  T                     i_dat,
    output T                     o_head,
    output logic                 o_empty,
    output logic                 o_full,
    output logic [DepthBits:0]   o_count
);

    localparam int unsigned Depth = 1 << DepthBits;

    T                     r_mem [Depth];
    logic [DepthBits-1:0] r_wr_ptr;
    logic [DepthBits-1:0] r_rd_ptr;
    logic [DepthBits:0]   r_count;
    logic                 w_push;
    logic                 w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (DepthBits+1)'(Depth));
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (DepthBits+1)'(w_push) - (DepthBits+1)'(w_pop);
        end
    end

    // Storage carries no reset: contents are only observed behind a non-empty count.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= i_dat;
    end

endmodule

// File: rtl/axi_ds_slave_model.sv
// AXI4 responder model for the IOMMU downstream port: in-order R bursts with an address
// pattern, W sunk against queued AWs, B issued the cycle after the last W beat.
module axi_ds_slave_model
    import axi_ds_model_pkg::*;
#(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned DepthBits = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ar_valid_i,
    output logic                 ar_ready_o,
    input  logic [AddrWidth-1:0] ar_addr_i,
    input  logic [7:0]           ar_len_i,
    input  logic [2:0]           ar_size_i,
    input  logic [IdWidth-1:0]   ar_id_i,
    output logic                 r_valid_o,
    input  logic                 r_ready_i,
    output logic [DataWidth-1:0] r_data_o,
    output logic [IdWidth-1:0]   r_id_o,
    output logic [1:0]           r_resp_o,
    output logic                 r_last_o,
    input  logic                 aw_valid_i,
    output logic                 aw_ready_o,
    input  logic [7:0]           aw_len_i,
    input  logic [IdWidth-1:0]   aw_id_i,
    input  logic                 w_valid_i,
    output logic                 w_ready_o,
    input  logic                 w_last_i,
    output logic                 b_valid_o,
    input  logic                 b_ready_i,
    output logic [IdWidth-1:0]   b_id_o,
    output logic [1:0]           b_resp_o,
    input  logic                 r_stall_i,
    output logic                 protocol_err_o,
    output logic [DepthBits:0]   rd_outstanding_o,
    output logic [DepthBits:0]   wr_outstanding_o
);

    ar_entry_t            w_ar_dat, w_ar_head;
    aw_entry_t            w_aw_dat, w_aw_head;
    b_entry_t             w_b_dat, w_b_head;
    logic                 w_ar_push, w_ar_pop, w_ar_empty, w_ar_full;
    logic                 w_aw_push, w_aw_pop, w_aw_empty, w_aw_full;
    logic                 w_b_push, w_b_pop, w_b_empty, w_b_full;
    logic [DepthBits:0]   w_b_count;
    logic [8:0]           r_rbeat, r_wbeat;
    logic                 r_hold, r_perr;
    logic                 w_r_fire, w_w_fire, w_w_end, w_len_hit;
    logic [AddrWidth-1:0] w_r_addr;

    // ---------------- read path ----------------
    assign ar_ready_o = !w_ar_full;
    assign w_ar_push  = ar_valid_i && ar_ready_o;

    always_comb begin
        w_ar_dat      = '0;
        w_ar_dat.addr = AddrWidthMax'(ar_addr_i);
        w_ar_dat.len  = ar_len_i;
        w_ar_dat.size = ar_size_i;
        w_ar_dat.id   = IdWidthMax'(ar_id_i);
    end

    axi_model_sync_fifo #(.T(ar_entry_t), .DepthBits(DepthBits)) u_ar_fifo (
        .clk_i, .rst_ni,
        .i_push (w_ar_push), .i_pop (w_ar_pop), .i_dat (w_ar_dat), .o_head (w_ar_head),
        .o_empty(w_ar_empty), .o_full(w_ar_full), .o_count(rd_outstanding_o)
    );

    // r_hold remembers an offered-but-not-taken beat so the stall hook cannot retract it.
    assign r_valid_o = !w_ar_empty && (!r_stall_i || r_hold);
    assign r_last_o  = beat_is_last(r_rbeat, w_ar_head.len);
    assign r_id_o    = IdWidth'(w_ar_head.id);
    assign r_resp_o  = RESP_OKAY;
    assign w_r_addr  = AddrWidth'(w_ar_head.addr) + (AddrWidth'(r_rbeat) << w_ar_head.size);
    assign r_data_o  = DataWidth'(w_r_addr);
    assign w_r_fire  = r_valid_o && r_ready_i;
    assign w_ar_pop  = w_r_fire && r_last_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rbeat <= '0;
            r_hold  <= 1'b0;
        end else begin
            r_hold <= r_valid_o && !r_ready_i;
            if (w_r_fire) r_rbeat <= r_last_o ? 9'd0 : r_rbeat + 9'd1;
        end
    end

    // ---------------- write path ----------------
    assign aw_ready_o = !w_aw_full;
    assign w_aw_push  = aw_valid_i && aw_ready_o;

    always_comb begin
        w_aw_dat     = '0;
        w_aw_dat.len = aw_len_i;
        w_aw_dat.id  = IdWidthMax'(aw_id_i);
    end

    axi_model_sync_fifo #(.T(aw_entry_t), .DepthBits(DepthBits)) u_aw_fifo (
        .clk_i, .rst_ni,
        .i_push (w_aw_push), .i_pop (w_aw_pop), .i_dat (w_aw_dat), .o_head (w_aw_head),
        .o_empty(w_aw_empty), .o_full(w_aw_full), .o_count(wr_outstanding_o)
    );

    // Holding W off while B is full guarantees every burst end has a B slot.
    assign w_ready_o = !w_aw_empty && !w_b_full;
    assign w_w_fire  = w_valid_i && w_ready_o;
    assign w_len_hit = beat_is_last(r_wbeat, w_aw_head.len);
    assign w_w_end   = w_w_fire && (w_last_i || w_len_hit);
    assign w_aw_pop  = w_w_end;
    assign w_b_push  = w_w_end;

    always_comb begin
        w_b_dat      = '0;
        w_b_dat.id   = w_aw_head.id;
        w_b_dat.resp = (w_last_i == w_len_hit) ? RESP_OKAY : RESP_SLVERR;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wbeat <= '0;
            r_perr  <= 1'b0;
        end else begin
            if (w_w_end)       r_wbeat <= '0;
            else if (w_w_fire) r_wbeat <= r_wbeat + 9'd1;
            if (w_w_end && (w_last_i != w_len_hit)) r_perr <= 1'b1;
        end
    end

    assign protocol_err_o = r_perr;

    axi_model_sync_fifo #(.T(b_entry_t), .DepthBits(DepthBits)) u_b_fifo (
        .clk_i, .rst_ni,
        .i_push (w_b_push), .i_pop (w_b_pop), .i_dat (w_b_dat), .o_head (w_b_head),
        .o_empty(w_b_empty), .o_full(w_b_full), .o_count(w_b_count)
    );

    assign b_valid_o = !w_b_empty;
    assign w_b_pop   = b_valid_o && b_ready_i;
    assign b_id_o    = IdWidth'(w_b_head.id);
    assign b_resp_o  = w_b_head.resp;

endmodule

// File: tb/tb_axi_ds_slave_model.sv
// Directed bench for axi_ds_slave_model: read bursts, AR backpressure, R stability, write responses, reset abort.
module tb_axi_ds_slave_model;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        ar_valid_i;
    logic        ar_ready_o;
    logic [63:0] ar_addr_i;
    logic [7:0]  ar_len_i;
    logic [2:0]  ar_size_i;
    logic [3:0]  ar_id_i;
    logic        r_valid_o;
    logic        r_ready_i;
    logic [63:0] r_data_o;
    logic [3:0]  r_id_o;
    logic [1:0]  r_resp_o;
    logic        r_last_o;
    logic        aw_valid_i;
    logic        aw_ready_o;
    logic [7:0]  aw_len_i;
    logic [3:0]  aw_id_i;
    logic        w_valid_i;
    logic        w_ready_o;
    logic        w_last_i;
    logic        b_valid_o;
    logic        b_ready_i;
    logic [3:0]  b_id_o;
    logic [1:0]  b_resp_o;
    logic        r_stall_i;
    logic        protocol_err_o;
    logic [3:0]  rd_outstanding_o;
    logic [3:0]  wr_outstanding_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    axi_ds_slave_model dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_addr_i(ar_addr_i),
        .ar_len_i(ar_len_i), .ar_size_i(ar_size_i), .ar_id_i(ar_id_i),
        .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_data_o(r_data_o), .r_id_o(r_id_o),
        .r_resp_o(r_resp_o), .r_last_o(r_last_o),
        .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_len_i(aw_len_i), .aw_id_i(aw_id_i),
        .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_last_i(w_last_i),
        .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o), .b_resp_o(b_resp_o),
        .r_stall_i(r_stall_i), .protocol_err_o(protocol_err_o),
        .rd_outstanding_o(rd_outstanding_o), .wr_outstanding_o(wr_outstanding_o)
    );

    // Inputs change 2ns after a rising edge; outputs are sampled 1ns later, mid-cycle.
    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        ar_valid_i = 0; ar_addr_i = '0; ar_len_i = '0; ar_size_i = '0; ar_id_i = '0;
        r_ready_i = 0; aw_valid_i = 0; aw_len_i = '0; aw_id_i = '0;
        w_valid_i = 0; w_last_i = 0; b_ready_i = 0; r_stall_i = 0;
        #12;
        n_checks++; if (r_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_r_valid got=%b exp=0", r_valid_o); end
        n_checks++; if (b_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_b_valid got=%b exp=0", b_valid_o); end
        n_checks++; if (ar_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ar_ready got=%b exp=1", ar_ready_o); end
        n_checks++; if (aw_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_aw_ready got=%b exp=1", aw_ready_o); end
        n_checks++; if (w_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_w_ready got=%b exp=0", w_ready_o); end
        n_checks++; if (protocol_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_perr got=%b exp=0", protocol_err_o); end
        n_checks++; if (rd_outstanding_o !== 4'd0) begin n_fail++; $display("FAIL reset_rd_out got=%0d exp=0", rd_outstanding_o); end
        n_checks++; if (wr_outstanding_o !== 4'd0) begin n_fail++; $display("FAIL reset_wr_out got=%0d exp=0", wr_outstanding_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_read_burst();
        ar_valid_i = 1; ar_addr_i = 64'h1000; ar_len_i = 8'd3; ar_size_i = 3'd3; ar_id_i = 4'd2;
        r_ready_i = 1;
        #1;
        n_checks++; if (r_valid_o !== 1'b0) begin n_fail++; $display("FAIL rb_no_early_valid got=%b exp=0", r_valid_o); end
        step();
        ar_valid_i = 0;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (r_valid_o !== 1'b1) begin n_fail++; $display("FAIL rb_valid beat=%0d got=%b exp=1", i, r_valid_o); end
            n_checks++; if (r_data_o !== 64'h1000 + 64'(i * 8)) begin n_fail++; $display("FAIL rb_data beat=%0d got=%h exp=%h", i, r_data_o, 64'h1000 + 64'(i * 8)); end
            n_checks++; if (r_last_o !== (i == 3)) begin n_fail++; $display("FAIL rb_last beat=%0d got=%b exp=%b", i, r_last_o, (i == 3)); end
            n_checks++; if (r_id_o !== 4'd2 || r_resp_o !== 2'b00) begin n_fail++; $display("FAIL rb_id_resp beat=%0d got=%0d/%b exp=2/00", i, r_id_o, r_resp_o); end
            n_checks++; if (rd_outstanding_o !== 4'd1) begin n_fail++; $display("FAIL rb_rd_out beat=%0d got=%0d exp=1", i, rd_outstanding_o); end
            step(); #1;
        end
        n_checks++; if (rd_outstanding_o !== 4'd0) begin n_fail++; $display("FAIL rb_rd_out_end got=%0d exp=0", rd_outstanding_o); end
        n_checks++; if (r_valid_o !== 1'b0) begin n_fail++; $display("FAIL rb_valid_end got=%b exp=0", r_valid_o); end
        r_ready_i = 0;
    endtask

    task automatic test_back_to_back();
        r_stall_i = 1; r_ready_i = 1;
        for (int i = 0; i < 8; i++) begin
            ar_valid_i = 1; ar_addr_i = 64'h2000 + 64'(i * 'h100); ar_len_i = 8'd0; ar_size_i = 3'd2; ar_id_i = 4'(i);
            step();
        end
        ar_addr_i = 64'h2800; ar_id_i = 4'd8;
        #1;
        n_checks++; if (ar_ready_o !== 1'b0) begin n_fail++; $display("FAIL b2b_full_ready got=%b exp=0", ar_ready_o); end
        n_checks++; if (rd_outstanding_o !== 4'd8) begin n_fail++; $display("FAIL b2b_rd_out got=%0d exp=8", rd_outstanding_o); end
        n_checks++; if (r_valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_stalled_valid got=%b exp=0", r_valid_o); end
        step();
        ar_valid_i = 0; r_stall_i = 0;
        #1;
        n_checks++; if (rd_outstanding_o !== 4'd8) begin n_fail++; $display("FAIL b2b_no_push_full got=%0d exp=8", rd_outstanding_o); end
        n_checks++; if (ar_ready_o !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_pop_cycle got=%b exp=0", ar_ready_o); end
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (r_valid_o !== 1'b1 || r_data_o !== 64'h2000 + 64'(i * 'h100) || r_id_o !== 4'(i) || r_last_o !== 1'b1)
                begin n_fail++; $display("FAIL b2b_order i=%0d got=%b/%h/%0d/%b exp=1/%h/%0d/1", i, r_valid_o, r_data_o, r_id_o, r_last_o, 64'h2000 + 64'(i * 'h100), i); end
            step(); #1;
            if (i == 0) begin
                n_checks++; if (ar_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_reopen got=%b exp=1", ar_ready_o); end
            end
        end
        n_checks++; if (rd_outstanding_o !== 4'd0) begin n_fail++; $display("FAIL b2b_rd_out_end got=%0d exp=0", rd_outstanding_o); end
        r_ready_i = 0;
    endtask

    task automatic test_r_backpressure();
        ar_valid_i = 1; ar_addr_i = 64'h3000; ar_len_i = 8'd2; ar_size_i = 3'd2; ar_id_i = 4'd5;
        r_ready_i = 0;
        step();
        ar_valid_i = 0; r_ready_i = 1;
        #1;
        n_checks++; if (r_data_o !== 64'h3000) begin n_fail++; $display("FAIL bp_beat0 got=%h exp=3000", r_data_o); end
        step();
        r_ready_i = 0;
        for (int k = 0; k < 5; k++) begin
            if (k >= 1) r_stall_i = 1;
            #1;
            n_checks++; if (r_valid_o !== 1'b1 || r_data_o !== 64'h3004 || r_id_o !== 4'd5 || r_last_o !== 1'b0)
                begin n_fail++; $display("FAIL bp_hold k=%0d got=%b/%h/%0d/%b exp=1/3004/5/0", k, r_valid_o, r_data_o, r_id_o, r_last_o); end
            step();
        end
        r_stall_i = 0; r_ready_i = 1;
        #1;
        n_checks++; if (r_data_o !== 64'h3004) begin n_fail++; $display("FAIL bp_release got=%h exp=3004", r_data_o); end
        step(); #1;
        n_checks++; if (r_data_o !== 64'h3008 || r_last_o !== 1'b1) begin n_fail++; $display("FAIL bp_last got=%h/%b exp=3008/1", r_data_o, r_last_o); end
        step(); #1;
        n_checks++; if (r_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_done got=%b exp=0", r_valid_o); end
        r_ready_i = 0;
    endtask

    task automatic test_write_ok();
        w_valid_i = 1; w_last_i = 0;
        #1;
        n_checks++; if (w_ready_o !== 1'b0) begin n_fail++; $display("FAIL wr_early_w_ready got=%b exp=0", w_ready_o); end
        step();
        w_valid_i = 0;
        aw_valid_i = 1; aw_len_i = 8'd1; aw_id_i = 4'd1;
        step();
        aw_valid_i = 0;
        #1;
        n_checks++; if (wr_outstanding_o !== 4'd1 || w_ready_o !== 1'b1) begin n_fail++; $display("FAIL wr_aw_queued got=%0d/%b exp=1/1", wr_outstanding_o, w_ready_o); end
        w_valid_i = 1; w_last_i = 0;
        step();
        w_last_i = 1;
        #1;
        n_checks++; if (b_valid_o !== 1'b0) begin n_fail++; $display("FAIL wr_b_early got=%b exp=0", b_valid_o); end
        step();
        w_valid_i = 0; w_last_i = 0;
        #1;
        n_checks++; if (b_valid_o !== 1'b1 || b_id_o !== 4'd1 || b_resp_o !== 2'b00) begin n_fail++; $display("FAIL wr_b_ok got=%b/%0d/%b exp=1/1/00", b_valid_o, b_id_o, b_resp_o); end
        n_checks++; if (wr_outstanding_o !== 4'd0) begin n_fail++; $display("FAIL wr_out_end got=%0d exp=0", wr_outstanding_o); end
        step(); #1;
        n_checks++; if (b_valid_o !== 1'b1 || b_id_o !== 4'd1) begin n_fail++; $display("FAIL wr_b_hold got=%b/%0d exp=1/1", b_valid_o, b_id_o); end
        b_ready_i = 1;
        step();
        b_ready_i = 0;
        #1;
        n_checks++; if (b_valid_o !== 1'b0) begin n_fail++; $display("FAIL wr_b_popped got=%b exp=0", b_valid_o); end
    endtask

    task automatic test_write_err();
        aw_valid_i = 1; aw_len_i = 8'd3; aw_id_i = 4'd3;
        step();
        aw_valid_i = 0;
        w_valid_i = 1; w_last_i = 0;
        step();
        w_last_i = 1;
        step();
        w_valid_i = 0; w_last_i = 0;
        #1;
        n_checks++; if (b_valid_o !== 1'b1 || b_id_o !== 4'd3 || b_resp_o !== 2'b10) begin n_fail++; $display("FAIL we_b_slverr got=%b/%0d/%b exp=1/3/10", b_valid_o, b_id_o, b_resp_o); end
        n_checks++; if (protocol_err_o !== 1'b1) begin n_fail++; $display("FAIL we_perr got=%b exp=1", protocol_err_o); end
        n_checks++; if (wr_outstanding_o !== 4'd0) begin n_fail++; $display("FAIL we_aw_popped got=%0d exp=0", wr_outstanding_o); end
        b_ready_i = 1;
        step();
        b_ready_i = 0;
        aw_valid_i = 1; aw_len_i = 8'd0; aw_id_i = 4'd4;
        step();
        aw_valid_i = 0;
        w_valid_i = 1; w_last_i = 1;
        step();
        w_valid_i = 0; w_last_i = 0;
        #1;
        n_checks++; if (b_valid_o !== 1'b1 || b_id_o !== 4'd4 || b_resp_o !== 2'b00) begin n_fail++; $display("FAIL we_b_ok_after got=%b/%0d/%b exp=1/4/00", b_valid_o, b_id_o, b_resp_o); end
        n_checks++; if (protocol_err_o !== 1'b1) begin n_fail++; $display("FAIL we_perr_sticky got=%b exp=1", protocol_err_o); end
        b_ready_i = 1;
        step();
        b_ready_i = 0;
    endtask

    task automatic test_reset_mid();
        ar_valid_i = 1; ar_addr_i = 64'h4000; ar_len_i = 8'd7; ar_size_i = 3'd3; ar_id_i = 4'd6;
        aw_valid_i = 1; aw_len_i = 8'd0; aw_id_i = 4'd7;
        r_ready_i = 1; b_ready_i = 0;
        step();
        ar_valid_i = 0; aw_valid_i = 0;
        w_valid_i = 1; w_last_i = 1;
        #1;
        n_checks++; if (rd_outstanding_o !== 4'd1 || wr_outstanding_o !== 4'd1) begin n_fail++; $display("FAIL rm_dual_push got=%0d/%0d exp=1/1", rd_outstanding_o, wr_outstanding_o); end
        n_checks++; if (r_valid_o !== 1'b1 || r_data_o !== 64'h4000) begin n_fail++; $display("FAIL rm_beat0 got=%b/%h exp=1/4000", r_valid_o, r_data_o); end
        step();
        w_valid_i = 0; w_last_i = 0;
        #1;
        n_checks++; if (b_valid_o !== 1'b1 || r_data_o !== 64'h4008) begin n_fail++; $display("FAIL rm_pending got=%b/%h exp=1/4008", b_valid_o, r_data_o); end
        rst_ni = 0;
        #1;
        n_checks++; if (r_valid_o !== 1'b0 || b_valid_o !== 1'b0) begin n_fail++; $display("FAIL rm_valids got=%b/%b exp=0/0", r_valid_o, b_valid_o); end
        n_checks++; if (ar_ready_o !== 1'b1 || aw_ready_o !== 1'b1 || w_ready_o !== 1'b0) begin n_fail++; $display("FAIL rm_readies got=%b/%b/%b exp=1/1/0", ar_ready_o, aw_ready_o, w_ready_o); end
        n_checks++; if (rd_outstanding_o !== 4'd0 || wr_outstanding_o !== 4'd0) begin n_fail++; $display("FAIL rm_counts got=%0d/%0d exp=0/0", rd_outstanding_o, wr_outstanding_o); end
        n_checks++; if (protocol_err_o !== 1'b0) begin n_fail++; $display("FAIL rm_perr got=%b exp=0", protocol_err_o); end
        step();
        rst_ni = 1;
        step(); step(); #1;
        n_checks++; if (r_valid_o !== 1'b0 || b_valid_o !== 1'b0) begin n_fail++; $display("FAIL rm_no_resp_after got=%b/%b exp=0/0", r_valid_o, b_valid_o); end
        r_ready_i = 0;
    endtask

    initial begin
        test_reset();
        test_read_burst();
        test_back_to_back();
        test_r_backpressure();
        test_write_ok();
        test_write_err();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
